// File: rtl/hv_abist_resp.sv
// HV analog BIST response emulator: six independent stimulus/response FSMs that
// return fault flags and ADC samples with programmable delay, hold and injection.
module hv_abist_resp #(
    parameter int                CLK_M    = 48,
    parameter int                ADC_DW   = 10,
    parameter int                DLY_OV   = 480,
    parameter int                DLY_FAST = 12,
    parameter int                DLY_ADC  = 96,
    parameter int                HOLD_CYC = 8,
    parameter logic [ADC_DW-1:0] ADC_GOOD = 10'h200,
    parameter logic [ADC_DW-1:0] ADC_BAD  = 10'h2FF,
    parameter logic [ADC_DW-1:0] ADC_IDLE = 10'h000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [5:0]        i_bist_stim,
    input  logic [4:0]        i_func_flt,
    input  logic [5:0]        i_inj_nrsp,
    input  logic [5:0]        i_inj_stuck,
    output logic              o_hv_vcc_ov,
    output logic              o_hv_ot,
    output logic              o_hv_desat_flt,
    output logic              o_hv_oc,
    output logic              o_hv_scp_flt,
    output logic [ADC_DW-1:0] o_hv_adc_data1,
    output logic [ADC_DW-1:0] o_hv_adc_data2,
    output logic              o_rsp_busy
);

    localparam int MAX_A = (DLY_OV > DLY_FAST) ? DLY_OV : DLY_FAST;
    localparam int MAX_B = (MAX_A > DLY_ADC) ? MAX_A : DLY_ADC;
    localparam int MAX_C = (MAX_B > HOLD_CYC) ? MAX_B : HOLD_CYC;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] D_OV    = CW'(DLY_OV);
    localparam logic [CW-1:0] D_FAST  = CW'(DLY_FAST);
    localparam logic [CW-1:0] D_ADC   = CW'(DLY_ADC);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    // The ADC item never blocks on no-response; it answers with ADC_BAD instead.
    localparam logic [5:0]    NRSP_BLOCKS = 6'b01_1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DLY  = 2'd1,
        ST_ACT  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e            state_r [6];
    state_e            state_s [6];
    logic [CW-1:0]     cnt_r   [6];
    logic [CW-1:0]     cnt_s   [6];
    logic [5:0]        act_s;
    logic [5:0]        busy_s;
    logic [4:0]        flag_r;
    logic [ADC_DW-1:0] adc_r;
    logic              busy_r;
    logic [31:0]       unused_clk_m_s;

    assign unused_clk_m_s = 32'(CLK_M);

    function automatic logic [CW-1:0] dly_of(input int idx);
        logic [CW-1:0] d;
        case (idx)
            32'sd0:  d = D_OV;
            32'sd5:  d = D_ADC;
            default: d = D_FAST;
        endcase
        return d;
    endfunction

    // Next-state and counter logic for every item FSM.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (i_bist_stim[i]) begin
                        state_s[i] = ST_DLY;
                        cnt_s[i]   = CNT_ONE;
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_DLY: begin
                    if (!i_bist_stim[i]) begin
                        state_s[i] = ST_IDLE;
                        cnt_s[i]   = '0;
                    end else if (cnt_r[i] == dly_of(i)) begin
                        // Blocked no-response parks here with the count held at the delay.
                        if (!(i_inj_nrsp[i] && NRSP_BLOCKS[i])) begin
                            state_s[i] = ST_ACT;
                        end else begin
                            state_s[i] = ST_DLY;
                        end
                    end else begin
                        cnt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                ST_ACT: begin
                    if (!i_bist_stim[i]) begin
                        state_s[i] = ST_HOLD;
                        cnt_s[i]   = CNT_ONE;
                    end else begin
                        state_s[i] = ST_ACT;
                    end
                end
                ST_HOLD: begin
                    if (i_bist_stim[i]) begin
                        state_s[i] = ST_ACT;
                    end else if (i_inj_stuck[i]) begin
                        state_s[i] = ST_HOLD;
                    end else if (cnt_r[i] == HOLD_C) begin
                        state_s[i] = ST_IDLE;
                        cnt_s[i]   = '0;
                    end else begin
                        cnt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                    cnt_s[i]   = '0;
                end
            endcase
            act_s[i]  = (state_s[i] == ST_ACT) || (state_s[i] == ST_HOLD);
            busy_s[i] = (state_r[i] != ST_IDLE);
        end
    end

    // State, counters and registered responses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 6; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= '0;
            end
            flag_r <= 5'b0_0000;
            adc_r  <= ADC_IDLE;
            busy_r <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
            flag_r <= act_s[4:0];
            if (act_s[5]) begin
                adc_r <= i_inj_nrsp[5] ? ADC_BAD : ADC_GOOD;
            end else begin
                adc_r <= ADC_IDLE;
            end
            busy_r <= |busy_s;
        end
    end

    // Functional faults bypass the emulator so they reach the sequencer without delay.
    assign o_hv_vcc_ov    = flag_r[0] | i_func_flt[0];
    assign o_hv_ot        = flag_r[1] | i_func_flt[1];
    assign o_hv_desat_flt = flag_r[2] | i_func_flt[2];
    assign o_hv_oc        = flag_r[3] | i_func_flt[3];
    assign o_hv_scp_flt   = flag_r[4] | i_func_flt[4];
    assign o_hv_adc_data1 = adc_r;
    assign o_hv_adc_data2 = adc_r;
    assign o_rsp_busy     = busy_r;

endmodule
